mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 36 +++
 rtl/mem_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the MMU-side op/line signals and the host-side beat
// signals of mem_ctrl.
//   slave  : view taken by mem_ctrl (accepts ops, issues host beats)
//   master : view taken by the environment (issues ops, answers host beats)
interface mem_ctrl_if;
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned LINE_W = 128;
   localparam int unsigned WORD_W = 32;

   // MMU side
   logic [1:0]        mem_op;
   logic [ADDR_W-1:0] cpu_addr;
   logic [LINE_W-1:0] wr_line;
   logic              ready;
   logic              tx_done;
   logic [LINE_W-1:0] rd_line;

   // host side
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [WORD_W-1:0] host_wdata;
   logic              host_gnt;
   logic              host_rvalid;
   logic [WORD_W-1:0] host_rdata;

   modport slave (
      input  mem_op, cpu_addr, wr_line, host_gnt, host_rvalid, host_rdata,
      output ready, tx_done, rd_line, host_req, host_we, host_addr, host_wdata
   );

   modport master (
      output mem_op, cpu_addr, wr_line, host_gnt, host_rvalid, host_rdata,
      input  ready, tx_done, rd_line, host_req, host_we, host_addr, host_wdata
   );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: splits a 16-byte line READ or WRITE from the MMU into four 32-bit
// host beats. Reads keep one beat outstanding at a time; writes issue beats
// back to back. tx_done pulses for one cycle when the line completes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_ctrl_if.slave
//                in : mem_op, cpu_addr, wr_line, host_gnt, host_rvalid, host_rdata
//                out: ready, tx_done, rd_line, host_req, host_we, host_addr, host_wdata
module mem_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   mem_ctrl_if.slave  bus
);
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned LINE_W = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned BEAT_W = 2;

   localparam logic [1:0]        OP_READ   = 2'b01;
   localparam logic [1:0]        OP_WRITE  = 2'b11;
   localparam logic [BEAT_W-1:0] LAST_BEAT = 2'd3;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

   state_t              state;
   logic [BEAT_W-1:0]   beat;
   logic [ADDR_W-1:0]   base;
   logic [LINE_W-1:0]   line;

   logic                ready_q;
   logic                tx_done_q;
   logic                host_req_q;
   logic                host_we_q;
   logic [ADDR_W-1:0]   host_addr_q;
   logic [WORD_W-1:0]   host_wdata_q;
   logic [LINE_W-1:0]   rd_line_q;

   logic [ADDR_W-1:0]   acc_base_c;
   logic [BEAT_W-1:0]   beat_inc_c;

   // Line base is the request address with the in-line offset cleared.
   assign acc_base_c = bus.cpu_addr & ~ADDR_W'(4'hF);
   assign beat_inc_c = beat + BEAT_W'(1);

   // Base is 16-byte aligned, so OR-ing the beat offset never carries.
   function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [BEAT_W-1:0] n);
      return b | ADDR_W'({n, 2'b00});
   endfunction

   function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0] l,
                                                 input logic [BEAT_W-1:0] n);
      return l[{n, 5'd0} +: WORD_W];
   endfunction

   // FSM with all outputs registered alongside the state transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         beat         <= '0;
         base         <= '0;
         line         <= '0;
         ready_q      <= 1'b1;
         tx_done_q    <= 1'b0;
         host_req_q   <= 1'b0;
         host_we_q    <= 1'b0;
         host_addr_q  <= '0;
         host_wdata_q <= '0;
         rd_line_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.mem_op == OP_READ || bus.mem_op == OP_WRITE) begin
                  base         <= acc_base_c;
                  line         <= bus.wr_line;
                  beat         <= '0;
                  ready_q      <= 1'b0;
                  host_req_q   <= 1'b1;
                  host_we_q    <= (bus.mem_op == OP_WRITE);
                  host_addr_q  <= acc_base_c;
                  host_wdata_q <= word_of(bus.wr_line, BEAT_W'(0));
                  state        <= (bus.mem_op == OP_WRITE) ? WR_REQ : RD_REQ;
               end
            end

            RD_REQ: begin
               if (bus.host_gnt) begin
                  host_req_q <= 1'b0;
                  state      <= RD_WAIT;
               end
            end

            RD_WAIT: begin
               if (bus.host_rvalid) begin
                  rd_line_q[{beat, 5'd0} +: WORD_W] <= bus.host_rdata;
                  if (beat == LAST_BEAT) begin
                     tx_done_q <= 1'b1;
                     state     <= DONE;
                  end else begin
                     beat         <= beat_inc_c;
                     host_addr_q  <= beat_addr(base, beat_inc_c);
                     host_wdata_q <= word_of(line, beat_inc_c);
                     host_req_q   <= 1'b1;
                     state        <= RD_REQ;
                  end
               end
            end

            WR_REQ: begin
               if (bus.host_gnt) begin
                  if (beat == LAST_BEAT) begin
                     host_req_q <= 1'b0;
                     host_we_q  <= 1'b0;
                     tx_done_q  <= 1'b1;
                     state      <= DONE;
                  end else begin
                     beat         <= beat_inc_c;
                     host_addr_q  <= beat_addr(base, beat_inc_c);
                     host_wdata_q <= word_of(line, beat_inc_c);
                  end
               end
            end

            DONE: begin
               tx_done_q <= 1'b0;
               ready_q   <= 1'b1;
               state     <= IDLE;
            end

            default: begin
               state      <= IDLE;
               ready_q    <= 1'b1;
               tx_done_q  <= 1'b0;
               host_req_q <= 1'b0;
               host_we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready      = ready_q;
   assign bus.tx_done    = tx_done_q;
   assign bus.rd_line    = rd_line_q;
   assign bus.host_req   = host_req_q;
   assign bus.host_we    = host_we_q;
   assign bus.host_addr  = host_addr_q;
   assign bus.host_wdata = host_wdata_q;
endmodule
